ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sequential successor to the combinational scan-code-to-character translator.
- Consumes the raw PS/2 set-2 byte stream from the keyboard receiver.
- Tracks E0/F0 prefixes, Shift and Caps Lock state internally, and generates letter case itself.
- Pushes translated character codes into an internal show-ahead FIFO drained by the VGA text writer over a valid/ready handshake.

Parameters:
- CODE_W, 9: width of the character code; must be >= 9.
- FIFO_DEPTH, 8: number of FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_valid  in  1  one-cycle strobe; scan_code is valid
- scan_code  in  8  received PS/2 byte
- code_valid  out  1  FIFO head valid
- code_ready  in  1  consumer accepts the head this cycle
- code_data  out  CODE_W  FIFO head character code
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- caps_lock  out  1  Caps Lock latch, intended for the keyboard LED
- shift_held  out  1  left or right Shift currently down
- overflow  out  1  sticky flag; a code was dropped because the FIFO was full
- clr_overflow  in  1  clears overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, Shift and Caps latches 0.
- Reset mid-sequence discards any pending prefix and all FIFO contents.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). The FSM only advances on scan_valid.
  - E0 in any state -> EXT.
  - F0: IDLE -> BRK, EXT -> EXT_BRK; BRK and EXT_BRK stay put.
  - Any other byte is processed as a make (IDLE, EXT) or a break (BRK, EXT_BRK), then the FSM returns to IDLE.
- Ignored bytes: in IDLE, 0xAA, 0xFA, 0xEE, 0xFE, 0x00 and 0xFF are dropped with no state change.
- Shift: make of 0x12 or 0x59 sets that key's held bit; the matching break clears it. shift_held is the OR of the two bits.
- Caps Lock: each make of 0x58 toggles caps_lock; the break has no effect.
- Modifier keys never push a code.
- Case: upper = shift_held XOR caps_lock, evaluated using the state before the current byte.
- Mapping (make only, non-extended):
  - Letters a..z: codes 1..26 when lower, 38..63 when upper.
  - Digits 0..9: codes 64..73 regardless of case.
  - Punctuation ` - = [ ] \ ; ' , . /: codes 27..37.
  - Space: 0x120. Enter: 0x0C0. Backspace: 0x108. Tab: 0x109.
  - Unmapped codes: nothing is pushed.
- Mapping (extended): only E0 5A (keypad Enter) maps, to 0x0C0. All other extended makes are dropped.
- Codes are zero-extended to CODE_W.
- Latency: the scan_valid cycle is N; the code is written at the N+1 edge. code_valid is high in cycle N+1 if the FIFO was empty.
- Handshake: a pop occurs when code_valid && code_ready. code_data is stable while code_valid is high and code_ready is low. code_ready while empty has no effect.
- FIFO full:
  - A push without a simultaneous pop is dropped and sets overflow.
  - Push and pop in the same cycle while full are both performed; count is unchanged.
- Overflow flag: clr_overflow has priority over a same-cycle set.

Optional Feature:
- Macro: KEY_REPEAT_FILTER_EN.
- When defined:
  - A register holds the last non-modifier make (9 bits: ext flag + byte) plus a held bit.
  - A make equal to the held key is a typematic repeat and is dropped.
  - A repeated 0x58 make does not re-toggle caps_lock.
  - The break of the held key clears the held bit.
  - A make of a different key replaces the register.
- When undefined: every make, including repeats, is translated, and every 0x58 make toggles caps_lock.

Decomposition:
- Package ps2_key_pkg holds:
  - scan constants: SC_EXT=0xE0, SC_BRK=0xF0, SC_LSHIFT, SC_RSHIFT, SC_CAPS;
  - character constants: CH_SPACE, CH_ENTER, CH_BKSP, CH_TAB;
  - FSM state enum typedef.
- One sub-module, ps2_scan_map: combinational map (scan, ext, upper) -> (code, hit). The top level holds the FSM, latches, repeat filter and FIFO.

Test Plan:
1. Reset, then 0x1C -> code_valid in the next cycle, code_data=1; after a pop, code_valid=0.
2. 0x12, 0x1C, F0 1C, F0 12, 0x1C -> codes 38 then 1. shift_held=1 between the 0x12 make and its break.
3. 0x58, F0 58, 0x16, 0x1C -> caps_lock=1; codes 65 then 38.
4. E0 5A -> 0x0C0. E0 75 -> nothing pushed. F0 1C -> nothing pushed. 0xAA -> ignored.
5. code_ready=0, ten 0x29 makes with FIFO_DEPTH=8 -> fifo_count=8, overflow=1. Full with simultaneous push and pop -> count stays 8. clr_overflow -> overflow=0.
6. With KEY_REPEAT_FILTER_EN: 0x1C 0x1C 0x1C F0 1C 0x1C -> exactly two codes of 1. Without the macro -> four codes.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared constants and types for the PS/2 set-2 key decoder.
//   - scan constants : prefix bytes, modifier keys, Enter
//   - char constants : character codes for whitespace/control keys
//   - kstate_t       : prefix-tracking FSM states
//   - is_ignored()   : keyboard status bytes that carry no key information
package ps2_key_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   localparam logic [8:0] CH_SPACE = 9'h120;
   localparam logic [8:0] CH_ENTER = 9'h0C0;
   localparam logic [8:0] CH_BKSP  = 9'h108;
   localparam logic [8:0] CH_TAB   = 9'h109;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } kstate_t;

   // BAT result, ACK, echo, resend and error bytes from the keyboard
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_scan_map.sv
// ps2_scan_map
// Combinational translation of one PS/2 set-2 make code into a character code.
// Ports:
//   scan  : received scan byte
//   ext   : byte was preceded by E0
//   upper : letters are produced in upper case
//   code  : character code, zero-extended to CODE_W
//   hit   : scan byte has a character mapping
module ps2_scan_map
   import ps2_key_pkg::*;
#(
   parameter int CODE_W = 9
) (
   input  logic [7:0]        scan,
   input  logic              ext,
   input  logic              upper,
   output logic [CODE_W-1:0] code,
   output logic              hit
);

   logic [4:0] letter;
   logic [8:0] c9;

   // Letters resolve to an alphabet index first so case is applied in one place;
   // upper-case codes sit 37 above their lower-case counterparts.
   always_comb begin
      letter = '0;
      c9     = '0;
      hit    = 1'b0;
      if (ext) begin
         if (scan == SC_ENTER) begin
            c9  = CH_ENTER;
            hit = 1'b1;
         end
      end else begin
         hit = 1'b1;
         case (scan)
            8'h1C: letter = 5'd1;   8'h32: letter = 5'd2;   8'h21: letter = 5'd3;
            8'h23: letter = 5'd4;   8'h24: letter = 5'd5;   8'h2B: letter = 5'd6;
            8'h34: letter = 5'd7;   8'h33: letter = 5'd8;   8'h43: letter = 5'd9;
            8'h3B: letter = 5'd10;  8'h42: letter = 5'd11;  8'h4B: letter = 5'd12;
            8'h3A: letter = 5'd13;  8'h31: letter = 5'd14;  8'h44: letter = 5'd15;
            8'h4D: letter = 5'd16;  8'h15: letter = 5'd17;  8'h2D: letter = 5'd18;
            8'h1B: letter = 5'd19;  8'h2C: letter = 5'd20;  8'h3C: letter = 5'd21;
            8'h2A: letter = 5'd22;  8'h1D: letter = 5'd23;  8'h22: letter = 5'd24;
            8'h35: letter = 5'd25;  8'h1A: letter = 5'd26;
            8'h45: c9 = 9'd64;      8'h16: c9 = 9'd65;      8'h1E: c9 = 9'd66;
            8'h26: c9 = 9'd67;      8'h25: c9 = 9'd68;      8'h2E: c9 = 9'd69;
            8'h36: c9 = 9'd70;      8'h3D: c9 = 9'd71;      8'h3E: c9 = 9'd72;
            8'h46: c9 = 9'd73;
            8'h0E: c9 = 9'd27;      8'h4E: c9 = 9'd28;      8'h55: c9 = 9'd29;
            8'h54: c9 = 9'd30;      8'h5B: c9 = 9'd31;      8'h5D: c9 = 9'd32;
            8'h4C: c9 = 9'd33;      8'h52: c9 = 9'd34;      8'h41: c9 = 9'd35;
            8'h49: c9 = 9'd36;      8'h4A: c9 = 9'd37;
            8'h29: c9 = CH_SPACE;
            8'h5A: c9 = CH_ENTER;
            8'h66: c9 = CH_BKSP;
            8'h0D: c9 = CH_TAB;
            default: hit = 1'b0;
         endcase
         if (letter != 5'd0) begin
            c9 = upper ? (9'(letter) + 9'd37) : 9'(letter);
         end
      end
   end

   assign code = CODE_W'(c9);

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the raw PS/2 set-2 byte stream into character codes queued in a
// show-ahead FIFO. Tracks E0/F0 prefixes, Shift and Caps Lock.
// Build option: KEY_REPEAT_FILTER_EN drops typematic repeats of the held key.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   scan_valid/scan_code: one-cycle strobe with received byte
//   code_valid/code_ready/code_data : FIFO head handshake
//   fifo_count          : FIFO occupancy
//   caps_lock           : Caps Lock latch (keyboard LED)
//   shift_held          : either Shift key is down
//   overflow/clr_overflow : sticky drop flag and its clear
module ps2_key_decoder
   import ps2_key_pkg::*;
#(
   parameter int CODE_W     = 9,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          scan_valid,
   input  logic [7:0]                    scan_code,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic [CODE_W-1:0]             code_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          caps_lock,
   output logic                          shift_held,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   kstate_t state, state_nxt;

   logic shift_l, shift_r;
   logic ext_cur, in_make, prefix, ignored, key_byte, make_key, brk_key;
   logic is_lshift, is_rshift, is_caps, is_repeat;
   logic map_hit;
   logic [CODE_W-1:0] map_code;
   logic push_req, caps_tgl, set_l, clr_l, set_r, clr_r;

   logic [CODE_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic full, pop, do_push;

   assign ext_cur   = (state == EXT) || (state == EXT_BRK);
   assign in_make   = (state == IDLE) || (state == EXT);
   assign prefix    = (scan_code == SC_EXT) || (scan_code == SC_BRK);
   assign ignored   = (state == IDLE) && is_ignored(scan_code);
   assign key_byte  = scan_valid && !prefix && !ignored;
   assign make_key  = key_byte && in_make;
   assign brk_key   = key_byte && !in_make;
   assign is_lshift = !ext_cur && (scan_code == SC_LSHIFT);
   assign is_rshift = !ext_cur && (scan_code == SC_RSHIFT);
   assign is_caps   = !ext_cur && (scan_code == SC_CAPS);

   // Case comes from the latches as they stood before this byte
   ps2_scan_map #(.CODE_W(CODE_W)) u_map (
      .scan  (scan_code),
      .ext   (ext_cur),
      .upper (shift_held ^ caps_lock),
      .code  (map_code),
      .hit   (map_hit)
   );

   // Prefix FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // E0 always moves to EXT; F0 adds the break qualifier; any key byte ends the sequence
   always_comb begin
      state_nxt = state;
      if (scan_valid) begin
         if (scan_code == SC_EXT) begin
            state_nxt = EXT;
         end else if (scan_code == SC_BRK) begin
            if (state == IDLE)     state_nxt = BRK;
            else if (state == EXT) state_nxt = EXT_BRK;
         end else if (!ignored) begin
            state_nxt = IDLE;
         end
      end
   end

   // Key actions for the current byte; modifiers update latches and never push
   always_comb begin
      set_l    = make_key && is_lshift;
      set_r    = make_key && is_rshift;
      clr_l    = brk_key && is_lshift;
      clr_r    = brk_key && is_rshift;
      caps_tgl = make_key && is_caps && !is_repeat;
      push_req = make_key && map_hit && !is_repeat &&
                 !is_lshift && !is_rshift && !is_caps;
   end

`ifdef KEY_REPEAT_FILTER_EN
   logic [8:0] held_key;
   logic       held;

   assign is_repeat = held && (held_key == {ext_cur, scan_code});

   // Caps Lock is captured here too so that its typematic repeats cannot re-toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_key <= '0;
         held     <= 1'b0;
      end else if (make_key && !is_lshift && !is_rshift) begin
         held_key <= {ext_cur, scan_code};
         held     <= 1'b1;
      end else if (brk_key && is_repeat) begin
         held     <= 1'b0;
      end
   end
`else
   assign is_repeat = 1'b0;
`endif

   // Modifier latches and the sticky overflow flag (clear wins over set)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps_lock <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (set_l)      shift_l <= 1'b1;
         else if (clr_l) shift_l <= 1'b0;
         if (set_r)      shift_r <= 1'b1;
         else if (clr_r) shift_r <= 1'b0;
         if (caps_tgl)   caps_lock <= ~caps_lock;
         if (clr_overflow)                       overflow <= 1'b0;
         else if (push_req && full && !pop)      overflow <= 1'b1;
      end
   end

   assign shift_held = shift_l | shift_r;

   assign full       = (count == CW'(FIFO_DEPTH));
   assign code_valid = (count != '0);
   assign pop        = code_valid && code_ready;
   assign do_push    = push_req && (!full || pop);
   assign fifo_count = count;
   assign code_data  = code_valid ? mem[rd_ptr] : '0;

   // FIFO pointers and occupancy; a pop frees the slot for a same-cycle push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(pop);
      end
   end

   // Storage is not reset; the head is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= map_code;
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder with a scoreboard of expected character
// codes; a monitor pops and compares every code the consumer accepts.
// Honours KEY_REPEAT_FILTER_EN for the repeat-sequence expectations.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scan_valid = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       code_valid;
   logic       code_ready = 1'b1;
   logic [8:0] code_data;
   logic [3:0] fifo_count;
   logic       caps_lock;
   logic       shift_held;
   logic       overflow;
   logic       clr_overflow = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   ps2_key_decoder #(.CODE_W(9), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .scan_valid   (scan_valid),
      .scan_code    (scan_code),
      .code_valid   (code_valid),
      .code_ready   (code_ready),
      .code_data    (code_data),
      .fifo_count   (fifo_count),
      .caps_lock    (caps_lock),
      .shift_held   (shift_held),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle scan strobe driven just after the rising edge
   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk); #1;
      scan_valid = 1'b1;
      scan_code  = b;
      @(posedge clk); #1;
      scan_valid = 1'b0;
   endtask

   task automatic expectCode(input logic [8:0] c);
      exp_q.push_back(c);
   endtask

   task automatic waitDrain();
      int cycles = 0;
      while ((exp_q.size() != 0 || code_valid) && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && code_valid && code_ready) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("[TB] FAIL extra_code observed=%0h expected=none", code_data);
         end
         if (exp_q.size() != 0) checkOutput("code", 32'(code_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", 32'(code_valid), 32'd0);
      checkOutput("rst_data", 32'(code_data), 32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_caps", 32'(caps_lock), 32'd0);
      checkOutput("rst_shift", 32'(shift_held), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      // 1: single letter, latency and pop
      expectCode(9'd1);
      applyStimulus(8'h1C);
      @(negedge clk);
      checkOutput("t1_valid", 32'(code_valid), 32'd1);
      checkOutput("t1_data", 32'(code_data), 32'd1);
      @(negedge clk);
      checkOutput("t1_popped", 32'(code_valid), 32'd0);

      // 2: shift-held upper case then lower case
      applyStimulus(8'h12);
      checkOutput("t2_shift_on", 32'(shift_held), 32'd1);
      expectCode(9'd38);
      applyStimulus(8'h1C);
      applyStimulus(8'hF0); applyStimulus(8'h1C);
      checkOutput("t2_shift_still", 32'(shift_held), 32'd1);
      applyStimulus(8'hF0); applyStimulus(8'h12);
      checkOutput("t2_shift_off", 32'(shift_held), 32'd0);
      expectCode(9'd1);
      applyStimulus(8'h1C);
      waitDrain();

      // 3: caps lock affects letters only
      applyStimulus(8'h58);
      applyStimulus(8'hF0); applyStimulus(8'h58);
      checkOutput("t3_caps_on", 32'(caps_lock), 32'd1);
      expectCode(9'd65);
      applyStimulus(8'h16);
      expectCode(9'd38);
      applyStimulus(8'h1C);
      applyStimulus(8'h58);
      applyStimulus(8'hF0); applyStimulus(8'h58);
      checkOutput("t3_caps_off", 32'(caps_lock), 32'd0);
      waitDrain();

      // 4: extended keys, dropped break, ignored status byte
      expectCode(9'h0C0);
      applyStimulus(8'hE0); applyStimulus(8'h5A);
      applyStimulus(8'hE0); applyStimulus(8'h75);
      applyStimulus(8'hF0); applyStimulus(8'h1C);
      applyStimulus(8'hAA);
      expectCode(9'd1);
      applyStimulus(8'h1C);
      waitDrain();
      expectCode(9'h108);
      applyStimulus(8'h66);
      expectCode(9'h109);
      applyStimulus(8'h0D);
      expectCode(9'd27);
      applyStimulus(8'h0E);
      waitDrain();

      // 5: overflow, full push+pop, clear
      code_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) expectCode(9'h120);
         applyStimulus(8'h29);
      end
      @(negedge clk);
      checkOutput("t5_count_full", 32'(fifo_count), 32'd8);
      checkOutput("t5_ovf", 32'(overflow), 32'd1);
      checkOutput("t5_head_hold", 32'(code_data), 32'h120);
      expectCode(9'h120);
      @(posedge clk); #1;
      scan_valid = 1'b1; scan_code = 8'h29; code_ready = 1'b1;
      @(posedge clk); #1;
      scan_valid = 1'b0; code_ready = 1'b0;
      @(negedge clk);
      checkOutput("t5_count_pushpop", 32'(fifo_count), 32'd8);
      checkOutput("t5_ovf_kept", 32'(overflow), 32'd1);
      @(posedge clk); #1; clr_overflow = 1'b1;
      @(posedge clk); #1; clr_overflow = 1'b0;
      checkOutput("t5_ovf_clr", 32'(overflow), 32'd0);
      code_ready = 1'b1;
      waitDrain();

      // Reset mid-sequence drops FIFO contents and a pending F0
      code_ready = 1'b0;
      applyStimulus(8'h1C);
      applyStimulus(8'hF0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;
      code_ready = 1'b1;
      expectCode(9'd1);
      applyStimulus(8'h1C);
      waitDrain();

      // 6: typematic repeats
      expectCode(9'd1);
`ifndef KEY_REPEAT_FILTER_EN
      expectCode(9'd1);
      expectCode(9'd1);
`endif
      expectCode(9'd1);
      applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
      applyStimulus(8'hF0); applyStimulus(8'h1C);
      applyStimulus(8'h1C);
      waitDrain();

      repeat (2) @(negedge clk);
      checkOutput("final_empty", 32'(code_valid), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
